// File: rtl/distance_monitor_pkg.sv
// Shared types and default constants for the ultrasonic distance path.
// Imported by the monitor, its sensor interface and the median filter.
package ultrasonic_pkg;

  typedef logic [7:0] dist_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIG   = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    FILTER = 3'd4
  } dm_state_t;

  localparam int unsigned DEF_PERIOD_CYCLES = 32'd3_000_000;
  localparam int unsigned DEF_NEAR_CM       = 32'd20;
  localparam int unsigned DEF_HYST_CM       = 32'd5;

endpackage

// File: rtl/distance_monitor_if.sv
// Link between distance_monitor (master) and sensor_driver (slave):
// the start pulse going out and the measured distance coming back.
interface distance_monitor_if;
  import ultrasonic_pkg::*;

  logic  measure;
  dist_t distance_in;

  modport master (output measure, input distance_in);
  modport slave  (input measure, output distance_in);

endinterface

// File: rtl/distance_monitor_median3.sv
// Combinational median of three unsigned distances.
module median3
  import ultrasonic_pkg::*;
(
  input  dist_t a,
  input  dist_t b,
  input  dist_t c,
  output dist_t med
);

  dist_t lo_ab_s;
  dist_t hi_ab_s;
  dist_t hi_c_s;

  // median = max(min(a,b), min(max(a,b),c))
  always_comb begin
    lo_ab_s = (a < b) ? a : b;
    hi_ab_s = (a < b) ? b : a;
    hi_c_s  = (hi_ab_s < c) ? hi_ab_s : c;
    med     = (lo_ab_s < hi_c_s) ? hi_c_s : lo_ab_s;
  end

endmodule

// File: rtl/distance_monitor.sv
// Schedules periodic sensor measurements, median-of-3 filters the results
// and drives a hysteretic proximity flag.
module distance_monitor
  import ultrasonic_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned NEAR_CM       = DEF_NEAR_CM,
  parameter int unsigned HYST_CM       = DEF_HYST_CM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  distance_monitor_if.master        sif,
  output dist_t                     filtered_distance,
  output logic                      sample_valid,
  output logic                      too_close,
  output logic [1:0]                sample_count
);

  localparam int unsigned      CNT_W    = (PERIOD_CYCLES > 32'd1) ? $clog2(PERIOD_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 32'd1);
  localparam dist_t            NEAR_T   = 8'(NEAR_CM);
  localparam logic [8:0]       FAR_T    = 9'(NEAR_CM + HYST_CM);

  dm_state_t        state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             measure_q, measure_d;
  dist_t            filt_q, filt_d;
  logic             valid_q, valid_d;
  logic             tc_q, tc_d;
  logic [1:0]       count_q, count_d;
  dist_t            h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;

  logic [1:0]       count_inc_s;
  dist_t            med_s;
  dist_t            result_s;

  // The filter runs on the post-shift history during SAMPLE so that the new
  // result, flag and count become visible together with sample_valid.
  median3 u_median3 (
    .a   (sif.distance_in),
    .b   (h0_q),
    .c   (h1_q),
    .med (med_s)
  );

  // Saturating history count and pass-through/median selection
  always_comb begin
    count_inc_s = (count_q == 2'd3) ? 2'd3 : (count_q + 2'd1);
    result_s    = (count_inc_s == 2'd3) ? med_s : sif.distance_in;
  end

  // Next-state and datapath logic for the measurement scheduler
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    filt_d    = filt_q;
    valid_d   = 1'b0;
    tc_d      = tc_q;
    count_d   = count_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    h2_d      = h2_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = TRIG;
        else        state_d = IDLE;
      end
      TRIG: begin
        counter_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        counter_d = counter_q + CNT_W'(1);
        if (counter_q == CNT_LAST) state_d = SAMPLE;
        else                       state_d = WAIT;
      end
      SAMPLE: begin
        h2_d    = h1_q;
        h1_d    = h0_q;
        h0_d    = sif.distance_in;
        count_d = count_inc_s;
        filt_d  = result_s;
        valid_d = 1'b1;
        if (!tc_q && (result_s < NEAR_T))                 tc_d = 1'b1;
        else if (tc_q && ({1'b0, result_s} >= FAR_T))     tc_d = 1'b0;
        else                                              tc_d = tc_q;
        state_d = FILTER;
      end
      FILTER: begin
        if (enable) state_d = TRIG;
        else        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    measure_d = (state_d == TRIG);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      measure_q <= 1'b0;
      filt_q    <= 8'd0;
      valid_q   <= 1'b0;
      tc_q      <= 1'b0;
      count_q   <= 2'd0;
      h0_q      <= 8'd0;
      h1_q      <= 8'd0;
      h2_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      measure_q <= measure_d;
      filt_q    <= filt_d;
      valid_q   <= valid_d;
      tc_q      <= tc_d;
      count_q   <= count_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      h2_q      <= h2_d;
    end
  end

  assign sif.measure       = measure_q;
  assign filtered_distance = filt_q;
  assign sample_valid      = valid_q;
  assign too_close         = tc_q;
  assign sample_count      = count_q;

endmodule
